// File: rtl/snake_engine.sv
// Multi-segment snake core: stepping, fruit growth, wall/self collision, pixel render.
// Define SNAKE_WRAP_EN to make the grid a torus (no wall collisions).
module snake_engine #(
  parameter int CELL     = 10,
  parameter int GRID_W   = 80,
  parameter int GRID_H   = 60,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 4,
  parameter int INIT_Y   = 4,
  parameter int XW       = $clog2(GRID_W),
  parameter int YW       = $clog2(GRID_H),
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          uclk,
  input  logic          reset,
  input  logic          mover,
  input  logic [2:0]    accion,
  input  logic [10:0]   PixelX,
  input  logic [10:0]   PixelY,
  input  logic [XW-1:0] fruitX,
  input  logic [YW-1:0] fruitY,
  input  logic [2:0]    Rfruta,
  input  logic [2:0]    Gfruta,
  input  logic [1:0]    Bfruta,
  output logic [2:0]    R,
  output logic [2:0]    G,
  output logic [1:0]    B,
  output logic          comer,
  output logic          game_over,
  output logic [LW-1:0] length
);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [2:0] UP    = 3'd1;
  localparam logic [2:0] DOWN  = 3'd2;
  localparam logic [2:0] LEFT  = 3'd3;
  localparam logic [2:0] RIGHT = 3'd4;

  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);

  localparam logic [7:0] C_HEAD = 8'b000_000_11;
  localparam logic [7:0] C_BODY = 8'b000_100_01;
  localparam logic [7:0] C_BG   = 8'b111_111_11;
  localparam logic [7:0] C_DEAD = 8'b100_000_00;

  typedef enum logic {RUN, OVER} state_t;

  state_t state, state_nx;

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [LW-1:0] len_q;
  logic [2:0]    dir, step_dir, rev_dir;
  logic          mover_q, step_q, comer_q;
  logic          dir_take;
  logic [XW-1:0] nhx;
  logic [YW-1:0] nhy;
  logic          wall, eat, self_hit, collide, move_ok;
  logic [31:0]   px, py;
  logic          in_grid, on_head, on_body, on_fruit;
  logic [7:0]    bg, pix, rgb;

  always_comb begin
    rev_dir = 3'd0;
    unique case (1'b1)
      dir == UP:    rev_dir = DOWN;
      dir == DOWN:  rev_dir = UP;
      dir == LEFT:  rev_dir = RIGHT;
      dir == RIGHT: rev_dir = LEFT;
      default:      rev_dir = 3'd0;
    endcase
  end

  assign dir_take = (state == RUN)
                  && (accion >= UP) && (accion <= RIGHT)
                  && !((len_q > LW'(1)) && (accion == rev_dir));

  // the pending move keeps the direction held when the edge was seen
  always_ff @(posedge uclk) begin
    if (!reset) begin
      dir      <= RIGHT;
      step_dir <= RIGHT;
      mover_q  <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      if (dir_take) dir <= accion;
      step_dir <= dir;
      mover_q  <= mover;
      step_q   <= mover & ~mover_q;
    end
  end

  always_comb begin
    nhx  = seg_x[0];
    nhy  = seg_y[0];
    wall = 1'b0;
    unique case (1'b1)
      step_dir == UP:
        if (seg_y[0] == '0) begin
          nhy  = YMAX;
          wall = !WRAP;
        end else nhy = seg_y[0] - 1'b1;
      step_dir == DOWN:
        if (seg_y[0] == YMAX) begin
          nhy  = '0;
          wall = !WRAP;
        end else nhy = seg_y[0] + 1'b1;
      step_dir == LEFT:
        if (seg_x[0] == '0) begin
          nhx  = XMAX;
          wall = !WRAP;
        end else nhx = seg_x[0] - 1'b1;
      step_dir == RIGHT:
        if (seg_x[0] == XMAX) begin
          nhx  = '0;
          wall = !WRAP;
        end else nhx = seg_x[0] + 1'b1;
      default: ;
    endcase
  end

  assign eat = (nhx == fruitX) && (nhy == fruitY);

  // the tail only vacates its cell when the snake does not grow
  always_comb begin
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (((i < int'(len_q) - 1) || (eat && (i == int'(len_q) - 1)))
          && (seg_x[i] == nhx) && (seg_y[i] == nhy))
        self_hit = 1'b1;
    end
  end

  assign collide = wall | self_hit;
  assign move_ok = (state == RUN) && step_q && !collide;

  always_ff @(posedge uclk) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? XW'(INIT_X - i) : '0;
        seg_y[i] <= YW'(INIT_Y);
      end
    end else if (move_ok) begin
      seg_x[0] <= nhx;
      seg_y[0] <= nhy;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
    end
  end

  always_ff @(posedge uclk) begin
    if (!reset) begin
      len_q   <= LW'(INIT_LEN);
      comer_q <= 1'b0;
    end else begin
      comer_q <= move_ok && eat;
      if (move_ok && eat && (len_q != LW'(MAX_LEN)))
        len_q <= len_q + 1'b1;
    end
  end

  always_ff @(posedge uclk) begin
    if (!reset) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if ((state == RUN) && step_q && collide) state_nx = OVER;
  end

  always_comb begin
    game_over = (state == OVER);
    bg        = (state == OVER) ? C_DEAD : C_BG;
  end

  function automatic logic in_span(input logic [31:0] p,
                                   input logic [31:0] c);
    return (p >= c * CELL) && (p < c * CELL + CELL);
  endfunction

  assign px      = 32'(PixelX);
  assign py      = 32'(PixelY);
  assign in_grid = (px < 32'(GRID_W * CELL)) && (py < 32'(GRID_H * CELL));

  always_comb begin
    on_head = in_span(px, 32'(seg_x[0])) && in_span(py, 32'(seg_y[0]));
    on_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i < int'(len_q))
          && in_span(px, 32'(seg_x[i])) && in_span(py, 32'(seg_y[i])))
        on_body = 1'b1;
    end
    on_fruit = in_span(px, 32'(fruitX)) && in_span(py, 32'(fruitY));
  end

  always_comb begin
    pix = bg;
    priority case (1'b1)
      !in_grid: pix = bg;
      on_head:  pix = C_HEAD;
      on_body:  pix = C_BODY;
      on_fruit: pix = {Rfruta, Gfruta, Bfruta};
      default:  pix = bg;
    endcase
  end

  always_ff @(posedge uclk) begin
    if (!reset) rgb <= '0;
    else        rgb <= pix;
  end

  assign R      = rgb[7:5];
  assign G      = rgb[4:2];
  assign B      = rgb[1:0];
  assign comer  = comer_q;
  assign length = len_q;

endmodule
